alu: RTL and testbench



---
 rtl/alu_pkg.sv | 31 +++
 rtl/alu_shifter.sv | 30 +++
 rtl/alu.sv | 76 +++++++
 tb/tb_alu.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the registered datapath ALU: widths, opcode encodings,
// shifter mode encoding and a bit-reverse helper used by the shifter.
package alu_pkg;

  localparam int DATA_W  = 32;
  localparam int OP_W    = 6;
  localparam int SHAMT_W = 5;

  localparam logic [OP_W-1:0] OP_ADD = 6'b010000;
  localparam logic [OP_W-1:0] OP_SUB = 6'b010001;
  localparam logic [OP_W-1:0] OP_EQ  = 6'b100000;
  localparam logic [OP_W-1:0] OP_NEQ = 6'b100001;
  localparam logic [OP_W-1:0] OP_LE  = 6'b100010;
  localparam logic [OP_W-1:0] OP_GT  = 6'b100011;
  localparam logic [OP_W-1:0] OP_SLL = 6'b110000;
  localparam logic [OP_W-1:0] OP_SRL = 6'b110001;
  localparam logic [OP_W-1:0] OP_SRA = 6'b110010;

  // Shifter mode select
  localparam logic [1:0] SH_LL = 2'd0;
  localparam logic [1:0] SH_RL = 2'd1;
  localparam logic [1:0] SH_RA = 2'd2;

  // Mirror a word so a left shift can reuse the right-shift network.
  function automatic logic [DATA_W-1:0] bit_rev(input logic [DATA_W-1:0] v);
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W; i++) r[i] = v[DATA_W-1-i];
    return r;
  endfunction

endpackage

// File: rtl/alu_shifter.sv
// Combinational 32-bit logarithmic barrel shifter: SLL, SRL, SRA.
// Left shifts are done by reversing the word around a single right-shift network.
module alu_shifter
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0]  data,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [1:0]         mode,
  output logic [DATA_W-1:0]  result
);

  logic              left;
  logic              fill;
  logic [DATA_W-1:0] cur;

  // Five binary stages, each shifting right by 2^i with the chosen fill bit.
  always_comb begin
    left = (mode == SH_LL);
    fill = (mode == SH_RA) & data[DATA_W-1];
    cur  = left ? bit_rev(data) : data;
    for (int i = 0; i < SHAMT_W; i++) begin
      if (shamt[i]) begin
        cur = (cur >> (1 << i)) |
              (fill ? ~({DATA_W{1'b1}} >> (1 << i)) : '0);
      end
    end
    result = left ? bit_rev(cur) : cur;
  end

endmodule

// File: rtl/alu.sv
// Registered 32-bit integer ALU: add/sub with carry/borrow, signed compares and
// shifts, one clock of latency, zero/negative flags derived from the result.
module alu
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [OP_W-1:0]   opCode,
  output logic [DATA_W-1:0] ans1,
  output logic              ans2,
  output logic              Z,
  output logic              N
);

  logic [DATA_W:0]   sum;
  logic [DATA_W:0]   diff;
  logic [1:0]        sh_mode;
  logic [DATA_W-1:0] sh_res;
  logic [DATA_W-1:0] res;
  logic              aux;

  // Shifter mode follows the opcode; non-shift opcodes ignore the shifter output.
  always_comb begin
    sh_mode = SH_LL;
    case (opCode)
      OP_SRL:  sh_mode = SH_RL;
      OP_SRA:  sh_mode = SH_RA;
      default: sh_mode = SH_LL;
    endcase
  end

  alu_shifter u_shifter (
    .data   (a),
    .shamt  (b[SHAMT_W-1:0]),
    .mode   (sh_mode),
    .result (sh_res)
  );

  // Result/aux select. The 33-bit difference's top bit is the unsigned borrow.
  always_comb begin
    sum  = {1'b0, a} + {1'b0, b};
    diff = {1'b0, a} - {1'b0, b};
    res  = '0;
    aux  = 1'b0;
    case (opCode)
      OP_ADD: begin res = sum[DATA_W-1:0];  aux = sum[DATA_W];  end
      OP_SUB: begin res = diff[DATA_W-1:0]; aux = diff[DATA_W]; end
      OP_EQ:  aux = (a == b);
      OP_NEQ: aux = (a != b);
      OP_LE:  aux = ($signed(a) <= $signed(b));
      OP_GT:  aux = ($signed(a) >  $signed(b));
      OP_SLL, OP_SRL, OP_SRA: res = sh_res;
      default: begin res = '0; aux = 1'b0; end
    endcase
    if (opCode == OP_EQ || opCode == OP_NEQ || opCode == OP_LE || opCode == OP_GT)
      res = {{(DATA_W-1){1'b0}}, aux};
  end

  // Output registers; reset clears the in-flight result and shows a zero word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ans1 <= '0;
      ans2 <= 1'b0;
      Z    <= 1'b1;
      N    <= 1'b0;
    end else begin
      ans1 <= res;
      ans2 <= aux;
      Z    <= (res == '0);
      N    <= res[DATA_W-1];
    end
  end

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for the registered ALU.
module tb_alu;
  import alu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [31:0] a, b;
  logic [5:0]  opCode;
  logic [31:0] ans1;
  logic        ans2, Z, N;

  int vecs = 0;
  int errs = 0;

  alu dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .opCode(opCode),
    .ans1(ans1), .ans2(ans2), .Z(Z), .N(N)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one operation at the falling edge, return 1 time unit after the rising edge.
  task automatic drive(input logic [5:0] op, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    opCode = op; a = x; b = y;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; opCode = OP_ADD; a = 32'hDEAD_BEEF; b = 32'h1234_5678;
    repeat (3) @(posedge clk);
    #1;
    vecs++;
    if (ans1 !== 32'h0 || ans2 !== 1'b0 || Z !== 1'b1 || N !== 1'b0) begin
      errs++;
      $display("FAIL reset_hold: got %h %b Z=%b N=%b want 00000000 0 Z=1 N=0", ans1, ans2, Z, N);
    end
    @(negedge clk);
    rst_n = 1'b1;
    opCode = OP_ADD; a = 32'h11; b = 32'h1;
    @(posedge clk); #1;
    vecs++;
    if (ans1 !== 32'h12 || Z !== 1'b0) begin
      errs++;
      $display("FAIL reset_first: got %h Z=%b want 00000012 Z=0", ans1, Z);
    end
  endtask

  task automatic test_reset_async();
    drive(OP_SUB, 32'h1, 32'hFFFF_FFFE);
    #2;
    rst_n = 1'b0;
    #1;
    vecs++;
    if (ans1 !== 32'h0 || ans2 !== 1'b0 || Z !== 1'b1 || N !== 1'b0) begin
      errs++;
      $display("FAIL reset_async: got %h %b Z=%b N=%b want 00000000 0 Z=1 N=0", ans1, ans2, Z, N);
    end
    @(negedge clk);
    rst_n = 1'b1;
    opCode = OP_ADD; a = 32'h1; b = 32'h1;
    #1;
    vecs++;
    if (ans1 !== 32'h0 || Z !== 1'b1) begin
      errs++;
      $display("FAIL reset_release_hold: got %h Z=%b want 00000000 Z=1", ans1, Z);
    end
    @(posedge clk); #1;
    vecs++;
    if (ans1 !== 32'h2) begin
      errs++;
      $display("FAIL reset_release_first: got %h want 00000002", ans1);
    end
  endtask

  task automatic test_sub();
    drive(OP_SUB, 32'h11, 32'h1);
    vecs++;
    if (ans1 !== 32'h10 || ans2 !== 1'b0 || Z !== 1'b0 || N !== 1'b0) begin
      errs++; $display("FAIL sub_basic: got %h %b Z=%b N=%b want 00000010 0 0 0", ans1, ans2, Z, N);
    end
    drive(OP_SUB, 32'h1, 32'h1);
    vecs++;
    if (ans1 !== 32'h0 || ans2 !== 1'b0 || Z !== 1'b1 || N !== 1'b0) begin
      errs++; $display("FAIL sub_zero: got %h %b Z=%b N=%b want 00000000 0 1 0", ans1, ans2, Z, N);
    end
    drive(OP_SUB, 32'h1, 32'hFFFF_FFFE);
    vecs++;
    if (ans1 !== 32'h3 || ans2 !== 1'b1 || Z !== 1'b0 || N !== 1'b0) begin
      errs++; $display("FAIL sub_borrow: got %h %b Z=%b N=%b want 00000003 1 0 0", ans1, ans2, Z, N);
    end
  endtask

  task automatic test_add();
    drive(OP_ADD, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    vecs++;
    if (ans1 !== 32'hFFFF_FFFD || ans2 !== 1'b1 || Z !== 1'b0 || N !== 1'b1) begin
      errs++; $display("FAIL add_carry: got %h %b Z=%b N=%b want fffffffd 1 0 1", ans1, ans2, Z, N);
    end
    drive(OP_ADD, 32'h11, 32'h1);
    vecs++;
    if (ans1 !== 32'h12 || ans2 !== 1'b0 || Z !== 1'b0 || N !== 1'b0) begin
      errs++; $display("FAIL add_basic: got %h %b Z=%b N=%b want 00000012 0 0 0", ans1, ans2, Z, N);
    end
    drive(OP_ADD, 32'hFFFF_FFFF, 32'h1);
    vecs++;
    if (ans1 !== 32'h0 || ans2 !== 1'b1 || Z !== 1'b1 || N !== 1'b0) begin
      errs++; $display("FAIL add_wrap: got %h %b Z=%b N=%b want 00000000 1 1 0", ans1, ans2, Z, N);
    end
  endtask

  task automatic test_compare();
    logic [5:0]  ops [6] = '{OP_EQ, OP_NEQ, OP_LE, OP_LE, OP_GT, OP_GT};
    logic [31:0] xs  [6] = '{32'h1, 32'h1, 32'hFFFF_FFFF, 32'h1, 32'h1, 32'h1};
    logic [31:0] ys  [6] = '{32'h1, 32'h1, 32'h1, 32'hFFFF_FFFE, 32'h2, 32'hFFFF_FFFE};
    logic        cs  [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 6; i++) begin
      drive(ops[i], xs[i], ys[i]);
      vecs++;
      if (ans2 !== cs[i] || ans1 !== {31'b0, cs[i]} || Z !== ~cs[i] || N !== 1'b0) begin
        errs++;
        $display("FAIL compare_%0d op=%b: got %h %b Z=%b N=%b want ans2=%b", i, ops[i], ans1, ans2, Z, N, cs[i]);
      end
    end
  endtask

  task automatic test_shift();
    logic [5:0]  ops [7] = '{OP_SLL, OP_SRL, OP_SRA, OP_SRA, OP_SLL, OP_SRA, OP_SRL};
    logic [31:0] xs  [7] = '{32'h0001_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1,
                             32'h0001_0000, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] ys  [7] = '{32'h1, 32'h2, 32'h2, 32'h1, 32'h21, 32'h1F, 32'hFFFF_FFFF};
    logic [31:0] rs  [7] = '{32'h0002_0000, 32'h3FFF_FFFF, 32'hFFFF_FFFF, 32'h0,
                             32'h0002_0000, 32'hFFFF_FFFF, 32'h1};
    for (int i = 0; i < 7; i++) begin
      drive(ops[i], xs[i], ys[i]);
      vecs++;
      if (ans1 !== rs[i] || ans2 !== 1'b0 || Z !== (rs[i] == 32'h0) || N !== rs[i][31]) begin
        errs++;
        $display("FAIL shift_%0d op=%b: got %h %b Z=%b N=%b want %h", i, ops[i], ans1, ans2, Z, N, rs[i]);
      end
    end
    drive(OP_SLL, 32'h1, 32'h1F);
    vecs++;
    if (ans1 !== 32'h8000_0000 || N !== 1'b1 || Z !== 1'b0) begin
      errs++; $display("FAIL shift_sll31: got %h N=%b want 80000000 N=1", ans1, N);
    end
  endtask

  task automatic test_undefined();
    logic [5:0] ops [3] = '{6'b000000, 6'b111111, 6'b010010};
    for (int i = 0; i < 3; i++) begin
      drive(ops[i], 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      vecs++;
      if (ans1 !== 32'h0 || ans2 !== 1'b0 || Z !== 1'b1 || N !== 1'b0) begin
        errs++;
        $display("FAIL undef op=%b: got %h %b Z=%b N=%b want 00000000 0 1 0", ops[i], ans1, ans2, Z, N);
      end
    end
  endtask

  // New op every cycle; before each edge the previous result must still be held,
  // even while inputs wiggle, and after it the new result appears.
  task automatic test_back_to_back();
    logic [5:0]  ops [5] = '{OP_ADD, OP_SUB, OP_EQ, OP_SLL, 6'b000000};
    logic [31:0] xs  [5] = '{32'h5, 32'h3, 32'h7, 32'h3, 32'h9};
    logic [31:0] ys  [5] = '{32'h3, 32'h5, 32'h7, 32'h4, 32'h9};
    logic [31:0] rs  [5] = '{32'h8, 32'hFFFF_FFFE, 32'h1, 32'h30, 32'h0};
    logic        cs  [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [31:0] prev;
    drive(OP_ADD, 32'h0, 32'h0);
    prev = 32'h0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      opCode = ops[i]; a = 32'hA5A5_A5A5; b = 32'h5A5A_5A5A;
      #1;
      a = xs[i]; b = ys[i];
      #1;
      vecs++;
      if (ans1 !== prev) begin
        errs++; $display("FAIL b2b_hold_%0d: got %h want %h", i, ans1, prev);
      end
      @(posedge clk); #1;
      vecs++;
      if (ans1 !== rs[i] || ans2 !== cs[i] || Z !== (rs[i] == 32'h0) || N !== rs[i][31]) begin
        errs++;
        $display("FAIL b2b_%0d: got %h %b Z=%b N=%b want %h %b", i, ans1, ans2, Z, N, rs[i], cs[i]);
      end
      prev = rs[i];
    end
  endtask

  initial begin
    rst_n = 1'b0; opCode = '0; a = '0; b = '0;
    test_reset();
    test_sub();
    test_add();
    test_compare();
    test_shift();
    test_undefined();
    test_back_to_back();
    test_reset_async();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
